// File: rtl/cp0_pkg.sv
// cp0_pkg: shared constants for the CP0 coprocessor slice.
//   - CP0 register indices used by mtc0/mfc0 (`number`)
//   - special ExcCode values (CAUSE_ERET marks an ERET report)
//   - SR and Cause field bit positions
package cp0_pkg;

  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_SR       = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;
  localparam logic [4:0] CP0_PRID     = 5'd15;

  // ExcCode 31 is reserved in the architecture, so it is free to mean ERET
  localparam logic [4:0] CAUSE_INT  = 5'd0;
  localparam logic [4:0] CAUSE_ERET = 5'd31;

  // SR fields
  localparam int SR_IE    = 0;
  localparam int SR_EXL   = 1;
  localparam int SR_IM_LO = 8;
  localparam int SR_IM_HI = 15;

  // Cause fields
  localparam int CAUSE_BD     = 31;
  localparam int CAUSE_TI     = 30;
  localparam int CAUSE_IP_LO  = 8;
  localparam int CAUSE_IP_HI  = 15;
  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_EXC_HI = 6;

endpackage

// File: rtl/cp0_intc_if.sv
// cp0_intc_if: pipeline <-> CP0 bus.
//   master (pipeline): drives mtc0 write (we/number/wdata), the commit-time
//                      exception report and pipe_has_exc; receives rdata,
//                      redirect/redirect_pc and irq_req.
//   slave  (cp0_intc): the opposite directions.
interface cp0_intc_if;
  logic        we;
  logic [4:0]  number;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        exc_valid;
  logic [4:0]  exc_cause;
  logic [31:0] exc_pc;
  logic [31:0] exc_badvaddr;
  logic        exc_is_bd;
  logic        pipe_has_exc;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        irq_req;

  modport master (
    output we, number, wdata, exc_valid, exc_cause, exc_pc, exc_badvaddr,
           exc_is_bd, pipe_has_exc,
    input  rdata, redirect, redirect_pc, irq_req
  );

  modport slave (
    input  we, number, wdata, exc_valid, exc_cause, exc_pc, exc_badvaddr,
           exc_is_bd, pipe_has_exc,
    output rdata, redirect, redirect_pc, irq_req
  );
endinterface

// File: rtl/cp0_timer.sv
// cp0_timer: Count/Compare timer. Only instantiated when CP0_TIMER_EN is
// defined.
//   clk, reset_n : clock, synchronous active-low reset
//   countWe      : accepted mtc0 to Count (also restarts the prescaler)
//   compareWe    : accepted mtc0 to Compare (also clears TI)
//   wdata        : write data
//   count        : current Count
//   compare      : current Compare
//   ti           : timer interrupt latch
module cp0_timer #(
  parameter int COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        countWe,
  input  logic        compareWe,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);

  localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

  logic [PW-1:0] presc;
  logic          tick;
  logic [31:0]   countNext;

  assign tick      = (presc == PW'(COUNT_DIV - 1));
  assign countNext = count + 32'd1;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      presc   <= '0;
      count   <= '0;
      compare <= '0;
      ti      <= 1'b0;
    end else begin
      // a Count write wins over the increment and restarts the prescaler
      if (countWe) begin
        count <= wdata;
        presc <= '0;
      end else if (tick) begin
        count <= countNext;
        presc <= '0;
      end else begin
        presc <= presc + 1'b1;
      end

      // a Compare write wins over a same-cycle match, so TI ends cleared
      if (compareWe) begin
        compare <= wdata;
        ti      <= 1'b0;
      end else if (!countWe && tick && (countNext == compare)) begin
        ti <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cp0_intc.sv
// cp0_intc: CP0 register file, exception entry / ERET redirect, interrupt
// controller and optional Count/Compare timer.
//   clk, reset_n : clock, synchronous active-low reset
//   hw_irq       : level-sensitive external interrupts, line k -> Cause.IP[2+k]
//   bus          : cp0_intc_if.slave (mtc0/mfc0, exception report, redirect,
//                  irq_req)
// Optional feature: define CP0_TIMER_EN to build the Count/Compare timer;
// without it Count/Compare read 0 and TI/IP[7] are tied low.
module cp0_intc
  import cp0_pkg::*;
#(
  parameter int          NUM_HW_IRQ = 5,
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
  parameter logic [31:0] PRID_VALUE = 32'hDEADBEEF,
  parameter int          COUNT_DIV  = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_HW_IRQ-1:0] hw_irq,
  cp0_intc_if.slave             bus
);

  if (NUM_HW_IRQ < 1 || NUM_HW_IRQ > 5) begin : gBadHw
    $error("cp0_intc: NUM_HW_IRQ must be 1..5");
  end
  if (COUNT_DIV < 1 || COUNT_DIV > 16) begin : gBadDiv
    $error("cp0_intc: COUNT_DIV must be 1..16");
  end

  // architectural state
  logic        exl, ie;
  logic [7:0]  im;
  logic [31:0] epc, badVAddr;
  logic        bd;
  logic [4:0]  excCode;
  logic [1:0]  ipSw;
  logic [4:0]  ipHw;

  logic [31:0] count, compare;
  logic        ti;

  logic        isEret, takeExc, takeEret, wrEn;
  logic [4:0]  hwPad;
  logic [7:0]  ip;
  logic [31:0] srVal, causeVal;

  assign isEret   = (bus.exc_cause == CAUSE_ERET);
  assign takeExc  = bus.exc_valid && !isEret && !exl;
  assign takeEret = bus.exc_valid &&  isEret &&  exl;
  // any reported event, taken or ignored, suppresses the mtc0 in that cycle
  assign wrEn     = bus.we && !bus.exc_valid;

  always_comb begin
    hwPad = '0;
    hwPad[NUM_HW_IRQ-1:0] = hw_irq;
  end

`ifdef CP0_TIMER_EN
  cp0_timer #(.COUNT_DIV(COUNT_DIV)) uTimer (
    .clk       (clk),
    .reset_n   (reset_n),
    .countWe   (wrEn && (bus.number == CP0_COUNT)),
    .compareWe (wrEn && (bus.number == CP0_COMPARE)),
    .wdata     (bus.wdata),
    .count     (count),
    .compare   (compare),
    .ti        (ti)
  );
`else
  assign count   = '0;
  assign compare = '0;
  assign ti      = 1'b0;
`endif

  assign ip = {ti, ipHw, ipSw};

  always_comb begin
    srVal = '0;
    srVal[SR_IM_HI:SR_IM_LO] = im;
    srVal[SR_EXL]            = exl;
    srVal[SR_IE]             = ie;
  end

  always_comb begin
    causeVal = '0;
    causeVal[CAUSE_BD]                    = bd;
    causeVal[CAUSE_TI]                    = ti;
    causeVal[CAUSE_IP_HI:CAUSE_IP_LO]     = ip;
    causeVal[CAUSE_EXC_HI:CAUSE_EXC_LO]   = excCode;
  end

  always_comb begin
    bus.rdata = '0;
    case (bus.number)
      CP0_BADVADDR: bus.rdata = badVAddr;
      CP0_COUNT:    bus.rdata = count;
      CP0_COMPARE:  bus.rdata = compare;
      CP0_SR:       bus.rdata = srVal;
      CP0_CAUSE:    bus.rdata = causeVal;
      CP0_EPC:      bus.rdata = epc;
      CP0_PRID:     bus.rdata = PRID_VALUE;
      default:      bus.rdata = '0;
    endcase
  end

  // outputs are forced quiet while reset is held
  assign bus.redirect    = reset_n && (takeExc || takeEret);
  assign bus.redirect_pc = takeEret ? epc : EXC_VECTOR;
  assign bus.irq_req     = reset_n && ie && !exl && !bus.pipe_has_exc && |(ip & im);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      exl      <= 1'b1;
      ie       <= 1'b0;
      im       <= 8'hFF;
      epc      <= '0;
      badVAddr <= '0;
      bd       <= 1'b0;
      excCode  <= '0;
      ipSw     <= '0;
      ipHw     <= '0;
    end else begin
      ipHw <= hwPad;
      if (takeExc) begin
        exl      <= 1'b1;
        bd       <= bus.exc_is_bd;
        excCode  <= bus.exc_cause;
        badVAddr <= bus.exc_badvaddr;
        // a delay-slot fault restarts at the branch
        epc      <= bus.exc_is_bd ? bus.exc_pc - 32'd4 : bus.exc_pc;
      end else if (takeEret) begin
        exl <= 1'b0;
      end else if (wrEn) begin
        case (bus.number)
          CP0_SR: begin
            im  <= bus.wdata[SR_IM_HI:SR_IM_LO];
            exl <= bus.wdata[SR_EXL];
            ie  <= bus.wdata[SR_IE];
          end
          CP0_CAUSE: ipSw <= bus.wdata[CAUSE_IP_LO+1:CAUSE_IP_LO];
          CP0_EPC:   epc  <= bus.wdata;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cp0_intc.sv
// tb_cp0_intc: scoreboard bench for cp0_intc. The driver computes each
// cycle's expected rdata/redirect/irq_req from a register-level model and
// queues it; a monitor on the falling edge pops and compares.
module tb_cp0_intc;
  import cp0_pkg::*;

  localparam int          NHW  = 5;
  localparam int          DIV  = 2;
  localparam logic [31:0] VEC  = 32'hBFC00380;
  localparam logic [31:0] PRID = 32'hDEADBEEF;
`ifdef CP0_TIMER_EN
  localparam bit TMR = 1'b1;
`else
  localparam bit TMR = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic [NHW-1:0] hw_irq = '0;

  cp0_intc_if bus();

  cp0_intc #(.NUM_HW_IRQ(NHW), .EXC_VECTOR(VEC), .PRID_VALUE(PRID), .COUNT_DIV(DIV)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .hw_irq  (hw_irq),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] rd;
    logic        redir;
    logic [31:0] rpc;
    logic        irq;
  } exp_t;

  exp_t q[$];
  int nCmp = 0;
  int nBad = 0;

  // reference model: architectural registers, Count as base + elapsed/DIV
  bit        mExl, mIe, mBd, mTi;
  bit [7:0]  mIm;
  bit [31:0] mEpc, mBadv, mCntBase, mCmp;
  bit [4:0]  mExc, mHw;
  bit [1:0]  mSw;
  longint    mCyc;

  // stimulus that persists across steps
  logic [NHW-1:0] hwV = '0;
  bit             pheV = 1'b0;

  function automatic bit [31:0] mCount();
    return TMR ? mCntBase + 32'(mCyc / DIV) : 32'h0;
  endfunction

  function automatic bit [31:0] mRead(bit [4:0] n);
    case (n)
      5'd8:    return mBadv;
      5'd9:    return mCount();
      5'd11:   return TMR ? mCmp : 32'h0;
      5'd12:   return {16'h0, mIm, 6'h0, mExl, mIe};
      5'd13:   return {mBd, mTi, 14'h0, mTi, mHw, mSw, 1'b0, mExc, 2'b0};
      5'd14:   return mEpc;
      5'd15:   return PRID;
      default: return 32'h0;
    endcase
  endfunction

  task automatic mReset();
    mExl = 1; mIe = 0; mIm = 8'hFF; mEpc = 0; mBadv = 0; mBd = 0; mExc = 0;
    mSw = 0; mHw = 0; mTi = 0; mCntBase = 0; mCmp = 0; mCyc = 0;
  endtask

  task automatic step(string nm, bit rst, bit we, bit [4:0] num, bit [31:0] wd,
                      bit ev, bit [4:0] cs, bit [31:0] pc, bit [31:0] bva, bit isbd);
    exp_t e;
    bit tExc, tEr, wr, cw, pw;
    bit [31:0] oldCnt;
    reset_n = rst; bus.we = we; bus.number = num; bus.wdata = wd;
    bus.exc_valid = ev; bus.exc_cause = cs; bus.exc_pc = pc; bus.exc_badvaddr = bva;
    bus.exc_is_bd = isbd; bus.pipe_has_exc = pheV; hw_irq = hwV;

    tExc = ev && (cs != CAUSE_ERET) && !mExl;
    tEr  = ev && (cs == CAUSE_ERET) && mExl;
    e.name  = nm;
    e.rd    = mRead(num);
    e.redir = rst && (tExc || tEr);
    e.rpc   = tEr ? mEpc : VEC;
    e.irq   = rst && mIe && !mExl && !pheV && ((({mTi, mHw, mSw}) & mIm) != 8'h0);
    q.push_back(e);

    if (!rst) mReset();
    else begin
      oldCnt = mCount();
      mHw = hwV;
      if (tExc) begin
        mExl = 1; mBd = isbd; mExc = cs; mBadv = bva;
        mEpc = isbd ? pc - 32'd4 : pc;
      end else if (tEr) mExl = 0;
      wr = we && !ev;
      cw = wr && num == 5'd9 && TMR;
      pw = wr && num == 5'd11 && TMR;
      if (wr) begin
        if (num == 5'd12) begin mIm = wd[15:8]; mExl = wd[1]; mIe = wd[0]; end
        if (num == 5'd13) mSw = wd[9:8];
        if (num == 5'd14) mEpc = wd;
      end
      if (cw) begin mCntBase = wd; mCyc = 0; end
      else mCyc++;
      if (pw) begin mCmp = wd; mTi = 0; end
      else if (TMR && !cw && mCount() != oldCnt && mCount() == mCmp) mTi = 1;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(string nm, bit [4:0] num);
    step(nm, 1, 0, num, 32'h0, 0, 5'd0, 32'h0, 32'h0, 0);
  endtask

  task automatic wrReg(string nm, bit [4:0] num, bit [31:0] wd);
    step(nm, 1, 1, num, wd, 0, 5'd0, 32'h0, 32'h0, 0);
  endtask

  task automatic excEv(string nm, bit [4:0] cs, bit [31:0] pc, bit isbd, bit [4:0] num);
    step(nm, 1, 0, num, 32'h0, 1, cs, pc, 32'hBAD0_0000 | pc, isbd);
  endtask

  // monitor
  initial begin
    exp_t e;
    bit ok;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        nCmp++;
        ok = (bus.rdata === e.rd) && (bus.redirect === e.redir) &&
             (!e.redir || bus.redirect_pc === e.rpc) && (bus.irq_req === e.irq);
        if (!ok) begin
          nBad++;
          $display("FAIL %s: got rdata=%h redirect=%b pc=%h irq=%b, want rdata=%h redirect=%b pc=%h irq=%b",
                   e.name, bus.rdata, bus.redirect, bus.redirect_pc, bus.irq_req,
                   e.rd, e.redir, e.rpc, e.irq);
        end
      end
    end
  end

  // driver
  initial begin
    bit [4:0] regs[7];
    bit [4:0] num, cs;
    bit [31:0] wd;
    regs = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15};
    reset_n = 0; bus.we = 0; bus.number = 0; bus.wdata = 0; bus.exc_valid = 0;
    bus.exc_cause = 0; bus.exc_pc = 0; bus.exc_badvaddr = 0; bus.exc_is_bd = 0;
    bus.pipe_has_exc = 0;
    @(posedge clk); #1;
    mReset();

    // reset: outputs quiet even with an event reported, then reset values
    step("rst_quiet", 0, 0, CP0_SR, 32'h0, 1, 5'd4, 32'h100, 32'h0, 0);
    idle("rst_sr", CP0_SR);
    idle("rst_prid", CP0_PRID);
    idle("rst_cause", CP0_CAUSE);

    // exception entry in a delay slot, then ERET
    wrReg("sr_ff01", CP0_SR, 32'h0000FF01);
    excEv("exc_entry", 5'd4, 32'h00003010, 1, CP0_EPC);
    idle("exc_epc", CP0_EPC);
    idle("exc_cause", CP0_CAUSE);
    idle("exc_badv", CP0_BADVADDR);
    idle("exc_sr", CP0_SR);
    excEv("eret", CAUSE_ERET, 32'h0, 0, CP0_SR);
    idle("eret_sr", CP0_SR);

    // exception beats a same-cycle EPC write
    step("exc_vs_we", 1, 1, CP0_EPC, 32'h1234, 1, 5'd5, 32'h4000, 32'h0, 0);
    idle("exc_vs_we_epc", CP0_EPC);
    excEv("exc_ignored", 5'd6, 32'h5000, 0, CP0_EPC);
    idle("exc_ignored_epc", CP0_EPC);
    excEv("eret2", CAUSE_ERET, 32'h0, 0, CP0_SR);
    excEv("eret_ignored", CAUSE_ERET, 32'h0, 0, CP0_SR);

    // hardware line 0 via IM[2]
    wrReg("sr_0401", CP0_SR, 32'h00000401);
    hwV = 5'b00001; idle("hw_pulse", CP0_CAUSE);
    hwV = 5'b00000; idle("hw_n1", CP0_CAUSE);
    idle("hw_n2", CP0_CAUSE);
    hwV = 5'b00001; idle("hw_hold", CP0_CAUSE);
    pheV = 1;       idle("hw_phe", CP0_CAUSE);
    pheV = 0;       idle("hw_nophe", CP0_CAUSE);
    hwV = 5'b00000; idle("hw_off", CP0_CAUSE);
    wrReg("sw_ip", CP0_CAUSE, 32'hFFFF_FFFF);
    idle("sw_ip_rd", CP0_CAUSE);
    wrReg("sr_0101", CP0_SR, 32'h00000101);
    idle("sw_irq", CP0_CAUSE);
    wrReg("sw_clr", CP0_CAUSE, 32'h0);

    // timer: Count=0, Compare=3, watch TI, then clear by Compare rewrite
    wrReg("sr_8001", CP0_SR, 32'h00008001);
    wrReg("cnt_wr", CP0_COUNT, 32'h0);
    wrReg("cmp_wr", CP0_COMPARE, 32'h3);
    for (int i = 0; i < 7; i++) idle("tmr_wait", CP0_CAUSE);
    idle("tmr_count", CP0_COUNT);
    wrReg("cmp_clr", CP0_COMPARE, 32'h100);
    idle("tmr_cleared", CP0_CAUSE);
    idle("ro_prid_pre", CP0_PRID);
    wrReg("ro_prid", CP0_PRID, 32'h0);
    wrReg("ro_badv", CP0_BADVADDR, 32'h0);
    idle("ro_prid_rd", CP0_PRID);
    idle("ro_badv_rd", CP0_BADVADDR);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      int r;
      r = $urandom_range(0, 9);
      num = (r < 7) ? regs[r] : 5'($urandom);
      wd = $urandom;
      if (num == CP0_COUNT && $urandom_range(0, 1) == 1) wd = mCmp - $urandom_range(0, 2);
      if ($urandom_range(0, 3) == 0) hwV = NHW'($urandom);
      pheV = ($urandom_range(0, 4) == 0);
      cs = ($urandom_range(0, 2) == 0) ? CAUSE_ERET : 5'($urandom_range(0, 30));
      step("rand", $urandom_range(0, 149) != 0, $urandom_range(0, 2) == 0, num, wd,
           $urandom_range(0, 7) == 0, cs, $urandom & 32'hFFFF_FFFC, $urandom,
           $urandom_range(0, 1) == 1);
    end
    hwV = '0; pheV = 0;
    idle("tail", CP0_SR);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      nBad++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
